// File: rtl/ring_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : ring_arbiter
//  Description : Round-robin arbiter for N requesters. A one-hot priority
//                pointer rotates past each winner. The grant is registered
//                and one-hot, and it is held while its owner keeps
//                requesting. It is force-released after MAX_HOLD cycles.
//                Every release is followed by one idle cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module ring_arbiter #(
    parameter int N        = 3,
    parameter int MAX_HOLD = 8,
    localparam int IW      = (N > 1) ? $clog2(N) : 1,
    localparam int HW      = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_id,
    output logic          busy,
    output logic          timeout
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t         r_state, w_state;
    logic [N-1:0]   r_ptr, w_ptr;
    logic [HW-1:0]  r_hcnt, w_hcnt;
    logic [N-1:0]   r_gnt, w_gnt;
    logic [IW-1:0]  r_gnt_id, w_gnt_id;
    logic           r_timeout, w_timeout;

    logic           w_found;
    logic [IW-1:0]  w_win;
    logic [N-1:0]   w_win_oh;
    logic           w_owner_req;

    // Winner search: the smallest upward distance from the pointer bit, with wrap.
    always_comb begin
        w_found  = 1'b0;
        w_win    = '0;
        w_win_oh = '0;
        for (int k = 0; k < N; k++) begin
            for (int i = 0; i < N; i++) begin
                if (!w_found && r_ptr[i] && req[(i + k) % N]) begin
                    w_found                = 1'b1;
                    w_win                  = IW'((i + k) % N);
                    w_win_oh[(i + k) % N]  = 1'b1;
                end
            end
        end
    end

    // The owner still requests. The grant is one-hot, so a masked OR is enough.
    assign w_owner_req = |(req & r_gnt);

    // Next-state and next-output logic for the IDLE/GRANT controller.
    always_comb begin
        w_state   = r_state;
        w_ptr     = r_ptr;
        w_hcnt    = r_hcnt;
        w_gnt     = r_gnt;
        w_gnt_id  = r_gnt_id;
        w_timeout = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_state  = GRANT;
                    w_gnt    = w_win_oh;
                    w_gnt_id = w_win;
                    w_hcnt   = HW'(1);
                    // Next priority goes to the neighbour above the winner.
                    w_ptr    = {w_win_oh[N-2:0], w_win_oh[N-1]};
                end
            end
            GRANT: begin
                if (!w_owner_req) begin
                    w_state  = IDLE;
                    w_gnt    = '0;
                    w_gnt_id = '0;
                    w_hcnt   = '0;
                end else if ((MAX_HOLD != 0) && (r_hcnt == HW'(MAX_HOLD))) begin
                    w_state   = IDLE;
                    w_gnt     = '0;
                    w_gnt_id  = '0;
                    w_hcnt    = '0;
                    w_timeout = 1'b1;
                end else if (r_hcnt != '1) begin
                    w_hcnt = r_hcnt + HW'(1);
                end
            end
            default: begin
                w_state  = IDLE;
                w_gnt    = '0;
                w_gnt_id = '0;
                w_hcnt   = '0;
            end
        endcase
    end

    // State and output registers. Reset clears everything at once, without waiting for a clock edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_ptr     <= N'(1);
            r_hcnt    <= '0;
            r_gnt     <= '0;
            r_gnt_id  <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_ptr     <= w_ptr;
            r_hcnt    <= w_hcnt;
            r_gnt     <= w_gnt;
            r_gnt_id  <= w_gnt_id;
            r_timeout <= w_timeout;
        end
    end

    assign gnt     = r_gnt;
    assign gnt_id  = r_gnt_id;
    assign busy    = |r_gnt;
    assign timeout = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_ring_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ring_arbiter
//  Description : Self-checking bench for ring_arbiter. It uses two instances
//                (MAX_HOLD=4 and MAX_HOLD=0). A behavioural model tracks the
//                owner and the last winner, and the bench runs directed
//                literal checks followed by random traffic.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ring_arbiter;

    localparam int N = 3;

    logic         clk;
    logic         rst;
    logic [N-1:0] req3, req0;
    logic [N-1:0] gnt3, gnt0;
    logic [1:0]   id3, id0;
    logic         busy3, busy0, tmo3, tmo0;

    int errors;
    int checks;

    ring_arbiter #(.N(N), .MAX_HOLD(4)) u_dut (
        .clk(clk), .rst(rst), .req(req3),
        .gnt(gnt3), .gnt_id(id3), .busy(busy3), .timeout(tmo3)
    );

    ring_arbiter #(.N(N), .MAX_HOLD(0)) u_dut_nohold (
        .clk(clk), .rst(rst), .req(req0),
        .gnt(gnt0), .gnt_id(id0), .busy(busy0), .timeout(tmo0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model state: the current owner (-1 when idle), the cycles held so far,
    // the index of the last winner, and whether the last release was forced.
    typedef struct {
        int owner;
        int held;
        int last;
        bit tmo;
    } mstate_t;

    mstate_t m3, m0;

    function automatic mstate_t mreset();
        mstate_t s;
        s.owner = -1;
        s.held  = 0;
        s.last  = N - 1;
        s.tmo   = 1'b0;
        return s;
    endfunction

    function automatic mstate_t mstep(mstate_t s, logic [N-1:0] r, int maxh);
        mstate_t n;
        n     = s;
        n.tmo = 1'b0;
        if (s.owner < 0) begin
            for (int k = 1; k <= N; k++) begin
                if (n.owner < 0 && r[(s.last + k) % N]) begin
                    n.owner = (s.last + k) % N;
                    n.held  = 1;
                    n.last  = n.owner;
                end
            end
        end else if (!r[s.owner]) begin
            n.owner = -1;
        end else if (maxh != 0 && s.held >= maxh) begin
            n.owner = -1;
            n.tmo   = 1'b1;
        end else begin
            n.held = s.held + 1;
        end
        return n;
    endfunction

    // Reference model, stepped on each rising edge and cleared asynchronously.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m3 <= mreset();
            m0 <= mreset();
        end else begin
            m3 <= mstep(m3, req3, 4);
            m0 <= mstep(m0, req0, 0);
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic compare_one(input string tag, input mstate_t m, input logic [N-1:0] g,
                               input logic [1:0] id, input logic b, input logic t);
        int eg;
        eg = (m.owner < 0) ? 0 : (1 << m.owner);
        chk({tag, "_gnt"},     int'(g),  eg);
        chk({tag, "_gnt_id"},  int'(id), (m.owner < 0) ? 0 : m.owner);
        chk({tag, "_busy"},    int'(b),  (m.owner < 0) ? 0 : 1);
        chk({tag, "_timeout"}, int'(t),  int'(m.tmo));
    endtask

    logic [N-1:0] exp_seq [16];
    logic         exp_tmo [16];
    logic [N-1:0] seq     [16];
    logic         tseq    [16];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        errors = 0;
        checks = 0;
        rst    = 1'b0;
        req3   = 3'b111;
        req0   = 3'b000;
        exp_seq = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b000,
                    3'b010, 3'b010, 3'b010, 3'b010, 3'b000,
                    3'b100, 3'b100, 3'b100, 3'b100, 3'b000, 3'b001};
        exp_tmo = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0};

        // Compare DUT against the model on every falling edge.
        fork
            forever begin
                @(negedge clk);
                compare_one("m4", m3, gnt3, id3, busy3, tmo3);
                compare_one("m0", m0, gnt0, id0, busy0, tmo0);
            end
        join_none

        // Reset held with every request active.
        repeat (3) @(negedge clk);
        #1;
        chk("rst_gnt",     int'(gnt3),  0);
        chk("rst_gnt_id",  int'(id3),   0);
        chk("rst_busy",    int'(busy3), 0);
        chk("rst_timeout", int'(tmo3),  0);
        rst = 1'b1;

        // Rotation with all requesters active and forced releases.
        @(negedge clk);
        for (int i = 0; i < 16; i++) begin
            if (i != 0) @(negedge clk);
            #1;
            seq[i]  = gnt3;
            tseq[i] = tmo3;
        end
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("rot_gnt[%0d]", i), int'(seq[i]), int'(exp_seq[i]));
            chk($sformatf("rot_tmo[%0d]", i), int'(tseq[i]), int'(exp_tmo[i]));
        end
        req3 = 3'b000;

        // Voluntary release after two granted cycles.
        @(negedge clk);
        req3 = 3'b010;
        @(negedge clk); #1;
        chk("vol_gnt_a", int'(gnt3), 3'b010);
        chk("vol_id",    int'(id3),  1);
        @(negedge clk); #1;
        chk("vol_gnt_b", int'(gnt3), 3'b010);
        req3 = 3'b000;
        @(negedge clk); #1;
        chk("vol_rel_gnt", int'(gnt3), 0);
        chk("vol_rel_tmo", int'(tmo3), 0);

        // Pointer wrap: after bit 2 is served, bit 0 beats bit 2.
        req3 = 3'b100;
        @(negedge clk); #1;
        chk("wrap_g2", int'(gnt3), 3'b100);
        req3 = 3'b000;
        @(negedge clk); #1;
        chk("wrap_idle", int'(gnt3), 0);
        req3 = 3'b101;
        @(negedge clk); #1;
        chk("wrap_win0", int'(gnt3), 3'b001);
        req3 = 3'b000;

        // Asynchronous reset while bit 1 is granted with hcnt=3.
        @(negedge clk); #1;
        req3 = 3'b010;
        @(negedge clk); #1;
        chk("mid_pre_gnt", int'(gnt3), 3'b010);
        repeat (2) @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("mid_rst_gnt",  int'(gnt3),  0);
        chk("mid_rst_busy", int'(busy3), 0);
        chk("mid_rst_tmo",  int'(tmo3),  0);
        req3 = 3'b110;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk); #1;
        chk("mid_after_gnt", int'(gnt3), 3'b010);
        chk("mid_after_id",  int'(id3),  1);
        req3 = 3'b000;

        // Unlimited hold: a sole requester keeps the grant.
        req0 = 3'b001;
        @(negedge clk);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk); #1;
            chk("nohold_gnt", int'(gnt0), 3'b001);
            chk("nohold_tmo", int'(tmo0), 0);
        end

        // Random traffic. Requests change rarely, so grants often reach the hold limit.
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk); #1;
            if ($urandom_range(3) == 0) req3 = 3'($urandom);
            if ($urandom_range(3) == 0) req0 = 3'($urandom);
        end

        @(negedge clk); #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
